blockram_access_controller: RTL and testbench

BLOCKRAM_ACCESS_CONTROLLER -- requirements
Module: blockram_access_controller

---
 rtl/blockram_access_controller.sv | 147 ++++++++++++++
 tb/tb_blockram_access_controller.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockram_access_controller.sv
// Sequences single-element reads and write/evict cycles against a dual-port blockram.
// Define BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN to return the overwritten element on the evict channel.
module blockram_access_controller #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   read_request_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_request_set_addr_in,
  output logic                                   read_request_ack_out,
  output logic                                   read_response_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_response_element_out,
  input  logic                                   read_response_ack_in,
  input  logic                                   write_request_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_request_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_request_element_in,
  output logic                                   write_request_ack_out,
  output logic                                   evict_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_out,
  input  logic                                   evict_ack_in,
  output logic                                   ram_read_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
  output logic                                   ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_evict_element_in,
  output logic [1:0]                             read_state_dbg,
  output logic [1:0]                             write_state_dbg
);

  localparam int W  = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  // Set addresses are passed through unchanged; the set count is informational only.
  localparam int unused_number_sets = NUMBER_SETS;

  // Handshake: a request/response transfers on a rising edge where its valid and its
  // ack are both high; a valid once raised by this block holds, with stable data,
  // until that edge. Request acks are combinational and forced low during reset.

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_CAPTURE, RD_RESPOND} rd_state_t;
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
  typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_CAPTURE, WR_EVICT} wr_state_t;
`else
  typedef enum logic [1:0] {WR_IDLE, WR_WRITE} wr_state_t;
`endif

  rd_state_t       rd_state, rd_next;
  wr_state_t       wr_state, wr_next;
  logic [AW-1:0]   rd_addr_q;
  logic [W-1:0]    rd_data_q;
  logic [AW-1:0]   wr_addr_q;
  logic [W-1:0]    wr_data_q;
  logic            rd_hazard;

  // A read may not overtake a write to the same set, so it always sees the new data.
  always_comb begin
    write_request_ack_out = !reset_in && write_request_valid_in && (wr_state == WR_IDLE);
    rd_hazard = ((wr_state != WR_IDLE) && (wr_addr_q == read_request_set_addr_in)) ||
                (write_request_ack_out && (write_request_set_addr_in == read_request_set_addr_in));
    read_request_ack_out = !reset_in && read_request_valid_in && (rd_state == RD_IDLE) &&
                           !rd_hazard;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:    if (read_request_ack_out) rd_next = RD_ISSUE;
      RD_ISSUE:   rd_next = RD_CAPTURE;
      RD_CAPTURE: rd_next = RD_RESPOND;
      RD_RESPOND: if (read_response_ack_in) rd_next = RD_IDLE;
      default:    rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_state  <= RD_IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_state <= rd_next;
      if (read_request_ack_out) rd_addr_q <= read_request_set_addr_in;
      if (rd_state == RD_CAPTURE) rd_data_q <= ram_read_element_in;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:    if (write_request_ack_out) wr_next = WR_WRITE;
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
      WR_WRITE:   wr_next = WR_CAPTURE;
      WR_CAPTURE: wr_next = WR_EVICT;
      WR_EVICT:   if (evict_ack_in) wr_next = WR_IDLE;
`else
      WR_WRITE:   wr_next = WR_IDLE;
`endif
      default:    wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_state  <= WR_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_state <= wr_next;
      if (write_request_ack_out) begin
        wr_addr_q <= write_request_set_addr_in;
        wr_data_q <= write_request_element_in;
      end
    end
  end

`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
  logic [W-1:0] ev_data_q;

  // The RAM presents the overwritten content the cycle after the write strobe.
  always_ff @(posedge clk_in) begin
    if (reset_in) ev_data_q <= '0;
    else if (wr_state == WR_CAPTURE) ev_data_q <= ram_evict_element_in;
  end

  assign evict_valid_out   = (wr_state == WR_EVICT);
  assign evict_element_out = ev_data_q;
`else
  logic unused_evict;
  assign unused_evict      = evict_ack_in ^ (^ram_evict_element_in);
  assign evict_valid_out   = 1'b0;
  assign evict_element_out = '0;
`endif

  assign ram_read_en_out           = (rd_state == RD_ISSUE);
  assign ram_read_set_addr_out     = rd_addr_q;
  assign read_response_valid_out   = (rd_state == RD_RESPOND);
  assign read_response_element_out = rd_data_q;
  assign ram_write_en_out          = (wr_state == WR_WRITE);
  assign ram_write_set_addr_out    = wr_addr_q;
  assign ram_write_element_out     = wr_data_q;
  assign read_state_dbg            = rd_state;
  assign write_state_dbg           = wr_state;

endmodule

// File: tb/tb_blockram_access_controller.sv
// Bench for blockram_access_controller: RAM model, transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_blockram_access_controller;
  localparam int W  = 64;
  localparam int AW = 6;
  localparam int NS = 64;

  logic          clk;
  logic          reset_in;
  logic          read_request_valid_in;
  logic [AW-1:0] read_request_set_addr_in;
  logic          read_request_ack_out;
  logic          read_response_valid_out;
  logic [W-1:0]  read_response_element_out;
  logic          read_response_ack_in;
  logic          write_request_valid_in;
  logic [AW-1:0] write_request_set_addr_in;
  logic [W-1:0]  write_request_element_in;
  logic          write_request_ack_out;
  logic          evict_valid_out;
  logic [W-1:0]  evict_element_out;
  logic          evict_ack_in;
  logic          ram_read_en_out;
  logic [AW-1:0] ram_read_set_addr_out;
  logic [W-1:0]  ram_read_element_in;
  logic          ram_write_en_out;
  logic [AW-1:0] ram_write_set_addr_out;
  logic [W-1:0]  ram_write_element_out;
  logic [W-1:0]  ram_evict_element_in;
  logic [1:0]    read_state_dbg;
  logic [1:0]    write_state_dbg;

  blockram_access_controller #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(NS), .SET_PTR_WIDTH_IN_BITS(AW)
  ) dut (
    .clk_in(clk), .reset_in(reset_in),
    .read_request_valid_in(read_request_valid_in),
    .read_request_set_addr_in(read_request_set_addr_in),
    .read_request_ack_out(read_request_ack_out),
    .read_response_valid_out(read_response_valid_out),
    .read_response_element_out(read_response_element_out),
    .read_response_ack_in(read_response_ack_in),
    .write_request_valid_in(write_request_valid_in),
    .write_request_set_addr_in(write_request_set_addr_in),
    .write_request_element_in(write_request_element_in),
    .write_request_ack_out(write_request_ack_out),
    .evict_valid_out(evict_valid_out), .evict_element_out(evict_element_out),
    .evict_ack_in(evict_ack_in),
    .ram_read_en_out(ram_read_en_out), .ram_read_set_addr_out(ram_read_set_addr_out),
    .ram_read_element_in(ram_read_element_in),
    .ram_write_en_out(ram_write_en_out), .ram_write_set_addr_out(ram_write_set_addr_out),
    .ram_write_element_out(ram_write_element_out),
    .ram_evict_element_in(ram_evict_element_in),
    .read_state_dbg(read_state_dbg), .write_state_dbg(write_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;
  int tcyc     = 0;
  int cyc      = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  function automatic logic [W-1:0] init_pat(input int i);
    return {32'h01234567, i[31:0]};
  endfunction

  // ---------------- blockram model ----------------
  logic [W-1:0] mem [NS];

  always @(posedge clk) begin
    if (ram_read_en_out) ram_read_element_in <= mem[ram_read_set_addr_out];
    if (ram_write_en_out) begin
      ram_evict_element_in         <= mem[ram_write_set_addr_out];
      mem[ram_write_set_addr_out]  <= ram_write_element_out;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0]  shadow [NS];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  ev_q[$];
  bit            rd_act    = 1'b0;
  bit            wr_act    = 1'b0;
  bit            after_rst = 1'b1;
  int            rd_acc    = 0;
  int            wr_acc    = 0;
  logic [AW-1:0] rd_a      = '0;
  logic [AW-1:0] wr_a      = '0;
  logic [W-1:0]  wr_d      = '0;

  // Inputs only change just after a rising edge, so at the falling edge they and the
  // combinational acks show exactly what the next rising edge will sample.
  always @(negedge clk) begin : compare
    bit rd_en_e, rd_val_e, wr_en_e, ev_val_e, wr_ack_e, rd_ack_e, hz;
    rd_en_e  = rd_act && (cyc == rd_acc + 1);
    rd_val_e = rd_act && (cyc >= rd_acc + 3);
    wr_en_e  = wr_act && (cyc == wr_acc + 1);
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
    ev_val_e = wr_act && (cyc >= wr_acc + 3);
`else
    ev_val_e = 1'b0;
`endif
    wr_ack_e = !reset_in && write_request_valid_in && !wr_act;
    hz = (wr_act && (wr_a == read_request_set_addr_in)) ||
         (wr_ack_e && (write_request_set_addr_in == read_request_set_addr_in));
    rd_ack_e = !reset_in && read_request_valid_in && !rd_act && !hz;

    chk("m_wr_ack", write_request_ack_out, wr_ack_e);
    chk("m_rd_ack", read_request_ack_out, rd_ack_e);
    chk("m_rd_en", ram_read_en_out, rd_en_e);
    if (rd_en_e) chk("m_rd_addr", ram_read_set_addr_out, rd_a);
    chk("m_rd_valid", read_response_valid_out, rd_val_e);
    if (rd_val_e && exp_q.size() > 0) chk("m_rd_data", read_response_element_out, exp_q[0]);
    chk("m_wr_en", ram_write_en_out, wr_en_e);
    if (wr_en_e) begin
      chk("m_wr_addr", ram_write_set_addr_out, wr_a);
      chk("m_wr_data", ram_write_element_out, wr_d);
    end
    chk("m_ev_valid", evict_valid_out, ev_val_e);
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
    if (ev_val_e && ev_q.size() > 0) chk("m_ev_data", evict_element_out, ev_q[0]);
`else
    chk("m_ev_data_tied", evict_element_out, '0);
`endif
    if (after_rst)
      chk("m_post_reset_zero",
          |{ram_read_set_addr_out, ram_write_set_addr_out, ram_write_element_out,
            read_response_element_out, evict_element_out}, 1'b0);

    if (reset_in) begin
      rd_act = 1'b0;
      wr_act = 1'b0;
      exp_q.delete();
      ev_q.delete();
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (rd_val_e && read_response_ack_in) begin
        rd_act = 1'b0;
        void'(exp_q.pop_front());
      end
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
      if (ev_val_e && evict_ack_in) begin
        wr_act = 1'b0;
        void'(ev_q.pop_front());
      end
`else
      if (wr_en_e) wr_act = 1'b0;
`endif
      if (wr_ack_e) begin
        wr_act = 1'b1;
        wr_acc = cyc;
        wr_a   = write_request_set_addr_in;
        wr_d   = write_request_element_in;
        ev_q.push_back(shadow[write_request_set_addr_in]);
        shadow[write_request_set_addr_in] = write_request_element_in;
      end
      if (rd_ack_e) begin
        rd_act = 1'b1;
        rd_acc = cyc;
        rd_a   = read_request_set_addr_in;
        exp_q.push_back(shadow[read_request_set_addr_in]);
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic issue_read(input logic [AW-1:0] a, output int acc_t);
    bit ok = 1'b0;
    acc_t = -1;
    read_request_set_addr_in = a;
    read_request_valid_in    = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (read_request_ack_out === 1'b1) begin
        ok = 1'b1;
        acc_t = tcyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    read_request_valid_in = 1'b0;
    chk("rd_ack_seen", ok, 1'b1);
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [W-1:0] d, output int acc_t);
    bit ok = 1'b0;
    acc_t = -1;
    write_request_set_addr_in = a;
    write_request_element_in  = d;
    write_request_valid_in    = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (write_request_ack_out === 1'b1) begin
        ok = 1'b1;
        acc_t = tcyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    write_request_valid_in = 1'b0;
    chk("wr_ack_seen", ok, 1'b1);
  endtask

  task automatic wait_read(output logic [W-1:0] d, output int n);
    bit ok = 1'b0;
    d = '0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (read_response_valid_out === 1'b1) begin
        ok = 1'b1;
        d = read_response_element_out;
        n = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_resp_seen", ok, 1'b1);
  endtask

`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
  task automatic wait_evict(output logic [W-1:0] d);
    bit ok = 1'b0;
    d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (evict_valid_out === 1'b1) begin
        ok = 1'b1;
        d = evict_element_out;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("evict_seen", ok, 1'b1);
  endtask
`endif

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0]  d;
    int            n, wt, rt;
    logic [AW-1:0] tab_a [4];
    logic [W-1:0]  tab_d [4];
    tab_a = '{6'd3, 6'd0, 6'd40, 6'd17};
    tab_d = '{64'h0, 64'h8000_0000_0000_0001, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_5678};

    reset_in                  = 1'b1;
    read_request_valid_in     = 1'b0;
    read_request_set_addr_in  = '0;
    read_response_ack_in      = 1'b1;
    write_request_valid_in    = 1'b0;
    write_request_set_addr_in = '0;
    write_request_element_in  = '0;
    evict_ack_in              = 1'b1;
    for (int i = 0; i < NS; i++) begin
      mem[i]    = init_pat(i);
      shadow[i] = init_pat(i);
    end

    // Requests presented during reset are never acked.
    @(posedge clk); #1;
    read_request_valid_in     = 1'b1;
    read_request_set_addr_in  = 6'd1;
    write_request_valid_in    = 1'b1;
    write_request_set_addr_in = 6'd2;
    @(negedge clk);
    chk("reset_rd_ack", read_request_ack_out, 1'b0);
    chk("reset_wr_ack", write_request_ack_out, 1'b0);
    chk("reset_rd_valid", read_response_valid_out, 1'b0);
    @(posedge clk); #1;
    read_request_valid_in  = 1'b0;
    write_request_valid_in = 1'b0;
    @(posedge clk); #1;
    reset_in = 1'b0;

    // Write then read back set 63; response three cycles after the read ack.
    issue_write(6'd63, 64'hFFFF_FFFF_0000_0000, wt);
    issue_read(6'd63, rt);
    wait_read(d, n);
    chk("r63_data", d, 64'hFFFF_FFFF_0000_0000);
    chk("r63_latency", n, 3);

    // Same-set write and read together: the read waits for the write to finish.
    fork
      issue_write(6'd62, 64'hFFFF_FFFF_FFFF_FFFF, wt);
      issue_read(6'd62, rt);
    join
    wait_read(d, n);
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
    chk("hazard_gap", rt - wt, 4);
`else
    chk("hazard_gap", rt - wt, 2);
`endif
    chk("r62_data", d, 64'hFFFF_FFFF_FFFF_FFFF);

    // Two writes to set 61; the second returns the first one's data as eviction.
    issue_write(6'd61, 64'h0000_0000_FFFF_FFFF, wt);
    issue_write(6'd61, 64'hFFFF_FFFF_0000_0000, wt);
`ifdef BLOCKRAM_ACCESS_CONTROLLER_EVICT_EN
    wait_evict(d);
    chk("evict61_data", d, 64'h0000_0000_FFFF_FFFF);
`endif

    // Response held for 10 cycles with ack low; a new read stays blocked meanwhile.
    read_response_ack_in = 1'b0;
    issue_read(6'd61, rt);
    wait_read(d, n);
    chk("hold_first", d, 64'hFFFF_FFFF_0000_0000);
    read_request_set_addr_in = 6'd7;
    read_request_valid_in    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", read_response_valid_out, 1'b1);
      chk("hold_data", read_response_element_out, 64'hFFFF_FFFF_0000_0000);
      chk("hold_rd_ack", read_request_ack_out, 1'b0);
    end
    @(posedge clk); #1;
    read_response_ack_in = 1'b1;
    issue_read(6'd7, rt);
    wait_read(d, n);
    chk("r7_data", d, 64'h0123_4567_0000_0007);

    // Different sets are accepted together and strobe the RAM in the same cycle.
    write_request_set_addr_in = 6'd5;
    write_request_element_in  = 64'hA5A5_5A5A_C3C3_3C3C;
    write_request_valid_in    = 1'b1;
    read_request_set_addr_in  = 6'd9;
    read_request_valid_in     = 1'b1;
    @(negedge clk);
    chk("conc_wr_ack", write_request_ack_out, 1'b1);
    chk("conc_rd_ack", read_request_ack_out, 1'b1);
    @(posedge clk); #1;
    write_request_valid_in = 1'b0;
    read_request_valid_in  = 1'b0;
    @(negedge clk);
    chk("conc_rd_en", ram_read_en_out, 1'b1);
    chk("conc_wr_en", ram_write_en_out, 1'b1);
    @(posedge clk); #1;
    wait_read(d, n);
    chk("r9_data", d, 64'h0123_4567_0000_0009);
    issue_read(6'd5, rt);
    wait_read(d, n);
    chk("r5_data", d, 64'hA5A5_5A5A_C3C3_3C3C);

    // Back-to-back table of writes, then read them all back.
    for (int i = 0; i < 4; i++) issue_write(tab_a[i], tab_d[i], wt);
    for (int i = 0; i < 4; i++) begin
      issue_read(tab_a[i], rt);
      wait_read(d, n);
      chk("table_data", d, tab_d[i]);
    end

    // Reset two cycles after a write is accepted: no evict afterwards, RAM keeps the data.
    issue_write(6'd20, 64'hDEAD_BEEF_CAFE_F00D, wt);
    @(posedge clk); #1;
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_wr_no_evict", evict_valid_out, 1'b0);
      chk("rst_wr_no_en", ram_write_en_out, 1'b0);
    end
    @(posedge clk); #1;
    issue_read(6'd20, rt);
    wait_read(d, n);
    chk("r20_after_reset", d, 64'hDEAD_BEEF_CAFE_F00D);

    // Reset while a read is issuing: its response never appears.
    issue_read(6'd30, rt);
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_rd_no_valid", read_response_valid_out, 1'b0);
      chk("rst_rd_no_en", ram_read_en_out, 1'b0);
    end
    @(posedge clk); #1;
    issue_read(6'd30, rt);
    wait_read(d, n);
    chk("r30_data", d, 64'h0123_4567_0000_001E);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
